// File: rtl/l2_cacheline_adaptor.sv
// Converts between 256-bit cache lines and 64-bit memory beats.
// Reads gather four beats into line_o; write-backs send a buffered line out as four beats.
module l2_cacheline_adaptor #(
  parameter  int s_offset = 5,
  parameter  int s_burst  = 64,
  localparam int s_line   = 8 * (2 ** s_offset),
  localparam int n_beats  = s_line / s_burst
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int cnt_w = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t              state_reg;
  logic [cnt_w-1:0]    cnt_reg;
  logic [s_line-1:0]   buf_reg;
  logic [s_burst-1:0]  buf_beats [n_beats];
  logic [31:0]         line_addr;
  logic                unused_addr_bits;

  // The memory side only sees line-aligned addresses.
  assign line_addr        = {address_i[31:s_offset], {s_offset{1'b0}}};
  assign unused_addr_bits = ^address_i[s_offset-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < n_beats; gi++) begin : g_beat_view
      assign buf_beats[gi] = buf_reg[s_burst*gi +: s_burst];
    end
  endgenerate

  assign burst_o = (state_reg == WR_BURST) ? buf_beats[cnt_reg] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      buf_reg   <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_o <= 1'b0;
          if (read_i) begin
            address_o <= line_addr;
            cnt_reg   <= '0;
            read_o    <= 1'b1;
            state_reg <= RD_BURST;
          end else if (write_i) begin
            address_o <= line_addr;
            buf_reg   <= line_i;
            cnt_reg   <= '0;
            write_o   <= 1'b1;
            state_reg <= WR_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[s_burst*cnt_reg +: s_burst] <= burst_i;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == last_beat) begin
              read_o    <= 1'b0;
              resp_o    <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == last_beat) begin
              write_o   <= 1'b0;
              resp_o    <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        default: begin
          resp_o    <= 1'b0;
          read_o    <= 1'b0;
          write_o   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: fills, write-backs, stalls, priority, reset abort.
module tb_l2_cacheline_adaptor;

  logic         clk;
  logic         reset;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_cmp;
  int n_fail;

  l2_cacheline_adaptor dut (
    .clk       (clk),
    .reset     (reset),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [63:0]  ra [4];
  logic [63:0]  rb [4];
  logic [63:0]  rc [4];
  logic [63:0]  re [4];
  logic [63:0]  rf [4];
  logic [63:0]  wd [4];
  logic [63:0]  wg [4];
  int           pat [7];
  logic [255:0] exp_line;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    ra = '{64'hA000_0000_0000_1000, 64'hA100_0000_0000_1001, 64'hA200_0000_0000_1002, 64'hA300_0000_0000_1003};
    rb = '{64'hB0B0_0000_1111_2222, 64'hB1B1_3333_4444_5555, 64'hB2B2_6666_7777_8888, 64'hB3B3_9999_AAAA_BBBB};
    rc = '{64'hC000_0000_0000_00C0, 64'hC100_0000_0000_00C1, 64'hC200_0000_0000_00C2, 64'hC300_0000_0000_00C3};
    re = '{64'hE000_0000_0000_00E0, 64'hE100_0000_0000_00E1, 64'hE200_0000_0000_00E2, 64'hE300_0000_0000_00E3};
    rf = '{64'hF000_1234_0000_00F0, 64'hF100_1234_0000_00F1, 64'hF200_1234_0000_00F2, 64'hF300_1234_0000_00F3};
    wd = '{64'hD000_0000_DDDD_0000, 64'hD100_0000_DDDD_0001, 64'hD200_0000_DDDD_0002, 64'hD300_0000_DDDD_0003};
    wg = '{64'h6000_5555_0000_0060, 64'h6100_5555_0000_0061, 64'h6200_5555_0000_0062, 64'h6300_5555_0000_0063};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    reset     = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    cyc();
    chk("rst_line_o", line_o, '0);
    chk("rst_address_o", 256'(address_o), '0);
    chk("rst_burst_o", 256'(burst_o), '0);
    chk("rst_ctrl", 256'({read_o, write_o, resp_o}), '0);
    reset = 1'b0;
    cyc();

    // 1: read fill, acks back-to-back
    read_i    = 1'b1;
    address_i = 32'h1234_5678;
    cyc();
    read_i = 1'b0;
    chk("t1_address_o", 256'(address_o), 256'h1234_5660);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_read_o_b%0d", k), 256'(read_o), 256'd1);
      chk($sformatf("t1_resp_o_b%0d", k), 256'(resp_o), 256'd0);
      resp_i  = 1'b1;
      burst_i = ra[k];
      cyc();
    end
    resp_i   = 1'b0;
    exp_line = {ra[3], ra[2], ra[1], ra[0]};
    chk("t1_resp_pulse", 256'(resp_o), 256'd1);
    chk("t1_read_o_low", 256'(read_o), 256'd0);
    chk("t1_line_o", line_o, exp_line);
    chk("t1_address_hold", 256'(address_o), 256'h1234_5660);
    cyc();
    chk("t1_resp_single", 256'(resp_o), 256'd0);

    // 2: write-back; line_i changes after the request to prove it is buffered
    line_i    = {wd[3], wd[2], wd[1], wd[0]};
    address_i = 32'h0000_ABFF;
    write_i   = 1'b1;
    cyc();
    write_i = 1'b0;
    line_i  = '0;
    chk("t2_address_o", 256'(address_o), 256'h0000_ABE0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_write_o_b%0d", k), 256'(write_o), 256'd1);
      chk($sformatf("t2_burst_o_b%0d", k), 256'(burst_o), 256'(wd[k]));
      resp_i = 1'b1;
      cyc();
    end
    resp_i = 1'b0;
    chk("t2_resp_pulse", 256'(resp_o), 256'd1);
    chk("t2_write_o_low", 256'(write_o), 256'd0);
    chk("t2_line_o_kept", line_o, exp_line);
    cyc();
    chk("t2_resp_single", 256'(resp_o), 256'd0);
    chk("t2_write_o_idle", 256'(write_o), 256'd0);

    // 3: stalled memory, ack pattern 1,0,0,1,1,0,1
    read_i    = 1'b1;
    address_i = 32'h8000_003F;
    cyc();
    read_i = 1'b0;
    chk("t3_address_o", 256'(address_o), 256'h8000_0020);
    begin
      int idx;
      idx = 0;
      for (int p = 0; p < 7; p++) begin
        chk($sformatf("t3_read_o_c%0d", p), 256'(read_o), 256'd1);
        chk($sformatf("t3_resp_o_c%0d", p), 256'(resp_o), 256'd0);
        resp_i  = (pat[p] != 0);
        burst_i = (pat[p] != 0) ? rb[idx] : 64'hDEAD_BEEF_DEAD_BEEF;
        if (pat[p] != 0) idx++;
        cyc();
      end
    end
    resp_i   = 1'b0;
    exp_line = {rb[3], rb[2], rb[1], rb[0]};
    chk("t3_resp_pulse", 256'(resp_o), 256'd1);
    chk("t3_line_o", line_o, exp_line);
    cyc();
    chk("t3_resp_single", 256'(resp_o), 256'd0);

    // 4: read and write requested together, read wins
    read_i    = 1'b1;
    write_i   = 1'b1;
    line_i    = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    address_i = 32'h0000_0100;
    cyc();
    read_i  = 1'b0;
    write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_write_o_b%0d", k), 256'(write_o), 256'd0);
      chk($sformatf("t4_read_o_b%0d", k), 256'(read_o), 256'd1);
      resp_i  = 1'b1;
      burst_i = rc[k];
      cyc();
    end
    resp_i   = 1'b0;
    exp_line = {rc[3], rc[2], rc[1], rc[0]};
    chk("t4_resp_pulse", 256'(resp_o), 256'd1);
    chk("t4_write_o_done", 256'(write_o), 256'd0);
    chk("t4_line_o", line_o, exp_line);
    cyc();

    // 5: reset after three beats of a read aborts it
    read_i    = 1'b1;
    address_i = 32'h4444_4444;
    cyc();
    read_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp_i  = 1'b1;
      burst_i = re[k];
      cyc();
    end
    resp_i = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t5_rst_line_o", line_o, '0);
    chk("t5_rst_address_o", 256'(address_o), '0);
    chk("t5_rst_ctrl", 256'({read_o, write_o, resp_o}), '0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t5_no_resp", 256'(resp_o), 256'd0);
    read_i = 1'b1;
    cyc();
    read_i = 1'b0;
    chk("t5_re_address_o", 256'(address_o), 256'h4444_4440);
    for (int k = 0; k < 4; k++) begin
      resp_i  = 1'b1;
      burst_i = rf[k];
      cyc();
    end
    resp_i   = 1'b0;
    exp_line = {rf[3], rf[2], rf[1], rf[0]};
    chk("t5_resp_pulse", 256'(resp_o), 256'd1);
    chk("t5_line_o", line_o, exp_line);
    cyc();

    // 6: stray acks in IDLE and read_i during a write are ignored
    resp_i  = 1'b1;
    burst_i = 64'h0BAD_0BAD_0BAD_0BAD;
    cyc();
    cyc();
    chk("t6_idle_read_o", 256'(read_o), 256'd0);
    chk("t6_idle_resp_o", 256'(resp_o), 256'd0);
    chk("t6_idle_line_o", line_o, exp_line);
    resp_i    = 1'b0;
    line_i    = {wg[3], wg[2], wg[1], wg[0]};
    address_i = 32'h0000_2010;
    write_i   = 1'b1;
    cyc();
    write_i   = 1'b0;
    read_i    = 1'b1;
    address_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_burst_o_b%0d", k), 256'(burst_o), 256'(wg[k]));
      chk($sformatf("t6_read_o_b%0d", k), 256'(read_o), 256'd0);
      resp_i = 1'b1;
      cyc();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    chk("t6_resp_pulse", 256'(resp_o), 256'd1);
    chk("t6_address_hold", 256'(address_o), 256'h0000_2000);
    chk("t6_line_o", line_o, exp_line);
    cyc();
    chk("t6_final_ctrl", 256'({read_o, write_o, resp_o}), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
